// File: rtl/nw_phase_sequencer.sv
// nw_phase_sequencer: handshake-driven phase controller for the Needleman-Wunsch
// datapath. It walks an N x M matrix cell by cell (READ -> INS -> NEXT), then runs
// traceback. A watchdog traps stalled handshakes in a sticky ERR state.
module nw_phase_sequencer #(
    parameter int N          = 5,
    parameter int M          = 5,
    parameter int INS_CYCLES = 4,
    parameter int TIMEOUT    = 255,
    parameter int IW         = $clog2(N + 1) + 1,
    parameter int JW         = $clog2(M + 1) + 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    input  logic               end_init,
    input  logic               calculated,
    input  logic               end_c,
    output logic               en_init,
    output logic               en_read,
    output logic               en_ins,
    output logic               we,
    output logic               change_index,
    output logic               en_traceB,
    output logic [IW-1:0]      i_cur,
    output logic [JW-1:0]      j_cur,
    output logic [IW+JW-1:0]   cells_done,
    output logic               busy,
    output logic               done,
    output logic               error
);

    localparam int CW  = IW + JW;
    localparam int WDW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam int ICW = (INS_CYCLES < 2) ? 1 : $clog2(INS_CYCLES + 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        INIT  = 3'd1,
        READ  = 3'd2,
        INS   = 3'd3,
        NEXT  = 3'd4,
        TRACE = 3'd5,
        DONE  = 3'd6,
        ERR   = 3'd7
    } state_t;

    state_t           state;
    state_t           next_state;
    logic [WDW-1:0]   wd_cnt;
    logic [ICW-1:0]   ins_cnt;
    logic             wd_expire;
    logic             ins_last;
    logic             last_cell;
    logic             row_end;
    logic             reinit;
    logic             wd_active;

    assign wd_expire = (wd_cnt == WDW'(TIMEOUT - 1));
    assign ins_last  = (ins_cnt == ICW'(INS_CYCLES - 1));
    assign row_end   = (j_cur == JW'(M));
    assign last_cell = (i_cur == IW'(N)) && row_end;
    assign wd_active = (state == INIT) || (state == READ) || (state == TRACE);

    // Counters restart on abort and on every fresh run launched from IDLE or DONE.
    assign reinit = ((next_state == IDLE) && (state != IDLE)) ||
                    ((next_state == INIT) && ((state == IDLE) || (state == DONE)));

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode; handshakes are tested before watchdog expiry so a
    // handshake arriving on the expiry edge still wins.
    always_comb begin
        next_state = state;
        if (abort) begin
            next_state = IDLE;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) next_state = INIT;
                end
                INIT: begin
                    if (end_init)       next_state = READ;
                    else if (wd_expire) next_state = ERR;
                end
                READ: begin
                    if (calculated)     next_state = READ == READ ? INS : INS;
                    else if (wd_expire) next_state = ERR;
                end
                INS: begin
                    if (ins_last) next_state = last_cell ? TRACE : NEXT;
                end
                NEXT: begin
                    next_state = READ;
                end
                TRACE: begin
                    if (end_c)          next_state = DONE;
                    else if (wd_expire) next_state = ERR;
                end
                DONE: begin
                    if (start) next_state = INIT;
                end
                ERR: begin
                    next_state = ERR;
                end
                default: next_state = IDLE;
            endcase
        end
    end

    // Watchdog: counts cycles spent waiting on a handshake, cleared on any state change.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd_cnt <= '0;
        end else if ((next_state != state) || !wd_active) begin
            wd_cnt <= '0;
        end else begin
            wd_cnt <= wd_cnt + WDW'(1);
        end
    end

    // Insertion hold counter: runs only while INS continues into INS.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ins_cnt <= '0;
        end else if ((state == INS) && (next_state == INS)) begin
            ins_cnt <= ins_cnt + ICW'(1);
        end else begin
            ins_cnt <= '0;
        end
    end

    // Cell index and fill-count tracking; abort/restart reinitialise first.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            i_cur      <= IW'(1);
            j_cur      <= JW'(1);
            cells_done <= '0;
        end else if (reinit) begin
            i_cur      <= IW'(1);
            j_cur      <= JW'(1);
            cells_done <= '0;
        end else if (!abort) begin
            if ((state == INS) && ins_last) begin
                cells_done <= cells_done + CW'(1);
            end
            if (state == NEXT) begin
                if (row_end) begin
                    j_cur <= JW'(1);
                    i_cur <= i_cur + IW'(1);
                end else begin
                    j_cur <= j_cur + JW'(1);
                end
            end
        end
    end

    // Registered Moore outputs decoded from the state being entered, so they
    // change on the same edge as the state itself.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en_init      <= 1'b0;
            en_read      <= 1'b0;
            en_ins       <= 1'b0;
            we           <= 1'b0;
            change_index <= 1'b0;
            en_traceB    <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            error        <= 1'b0;
        end else begin
            en_init      <= (next_state == INIT);
            en_read      <= (next_state == READ);
            en_ins       <= (next_state == INS);
            we           <= (next_state == INIT) || (next_state == INS);
            change_index <= (next_state == NEXT);
            en_traceB    <= (next_state == TRACE);
            busy         <= (next_state == INIT) || (next_state == READ) ||
                            (next_state == INS)  || (next_state == NEXT) ||
                            (next_state == TRACE);
            done         <= (next_state == DONE);
            error        <= (next_state == ERR);
        end
    end

endmodule

// File: tb/tb_nw_phase_sequencer.sv
// tb_nw_phase_sequencer: three sequencer instances (5x5, 3x7 with a short
// watchdog, 1x1) driven by a handshake responder; expected cell order is
// queued at run start and popped as each insertion burst begins.
module tb_nw_phase_sequencer;

    localparam int IW0 = $clog2(5 + 1) + 1;
    localparam int JW0 = $clog2(5 + 1) + 1;
    localparam int IW1 = $clog2(3 + 1) + 1;
    localparam int JW1 = $clog2(7 + 1) + 1;
    localparam int IW2 = $clog2(1 + 1) + 1;
    localparam int JW2 = $clog2(1 + 1) + 1;

    logic       clk = 1'b0;
    logic [2:0] rst, start, abort, end_init, calculated, end_c;
    logic [2:0] en_init, en_read, en_ins, we, change_index, en_traceB, busy, done, error;

    logic [IW0-1:0]     i0;
    logic [JW0-1:0]     j0;
    logic [IW0+JW0-1:0] c0;
    logic [IW1-1:0]     i1;
    logic [JW1-1:0]     j1;
    logic [IW1+JW1-1:0] c1;
    logic [IW2-1:0]     i2;
    logic [JW2-1:0]     j2;
    logic [IW2+JW2-1:0] c2;

    int icur [3];
    int jcur [3];
    int cells[3];

    int n_checks = 0;
    int n_errors = 0;
    int exp_q[$];

    always #5 clk = ~clk;

    always_comb begin
        icur[0] = int'(i0); jcur[0] = int'(j0); cells[0] = int'(c0);
        icur[1] = int'(i1); jcur[1] = int'(j1); cells[1] = int'(c1);
        icur[2] = int'(i2); jcur[2] = int'(j2); cells[2] = int'(c2);
    end

    nw_phase_sequencer #(.N(5), .M(5), .INS_CYCLES(4), .TIMEOUT(255)) u_dut0 (
        .clk(clk), .rst(rst[0]), .start(start[0]), .abort(abort[0]),
        .end_init(end_init[0]), .calculated(calculated[0]), .end_c(end_c[0]),
        .en_init(en_init[0]), .en_read(en_read[0]), .en_ins(en_ins[0]), .we(we[0]),
        .change_index(change_index[0]), .en_traceB(en_traceB[0]),
        .i_cur(i0), .j_cur(j0), .cells_done(c0),
        .busy(busy[0]), .done(done[0]), .error(error[0])
    );

    nw_phase_sequencer #(.N(3), .M(7), .INS_CYCLES(2), .TIMEOUT(16)) u_dut1 (
        .clk(clk), .rst(rst[1]), .start(start[1]), .abort(abort[1]),
        .end_init(end_init[1]), .calculated(calculated[1]), .end_c(end_c[1]),
        .en_init(en_init[1]), .en_read(en_read[1]), .en_ins(en_ins[1]), .we(we[1]),
        .change_index(change_index[1]), .en_traceB(en_traceB[1]),
        .i_cur(i1), .j_cur(j1), .cells_done(c1),
        .busy(busy[1]), .done(done[1]), .error(error[1])
    );

    nw_phase_sequencer #(.N(1), .M(1), .INS_CYCLES(3), .TIMEOUT(255)) u_dut2 (
        .clk(clk), .rst(rst[2]), .start(start[2]), .abort(abort[2]),
        .end_init(end_init[2]), .calculated(calculated[2]), .end_c(end_c[2]),
        .en_init(en_init[2]), .en_read(en_read[2]), .en_ins(en_ins[2]), .we(we[2]),
        .change_index(change_index[2]), .en_traceB(en_traceB[2]),
        .i_cur(i2), .j_cur(j2), .cells_done(c2),
        .busy(busy[2]), .done(done[2]), .error(error[2])
    );

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Outputs of a sequencer sitting in IDLE.
    task automatic check_idle(input int d, input string tag);
        check({tag, "_busy"},  int'(busy[d]), 0);
        check({tag, "_done"},  int'(done[d]), 0);
        check({tag, "_error"}, int'(error[d]), 0);
        check({tag, "_en"},    int'({en_init[d], en_read[d], en_ins[d], we[d],
                                     change_index[d], en_traceB[d]}), 0);
        check({tag, "_i"},     icur[d], 1);
        check({tag, "_j"},     jcur[d], 1);
        check({tag, "_cells"}, cells[d], 0);
    endtask

    // Full run from IDLE/DONE; returns early in the INS of cell stop_cell (>=0).
    task automatic run_fill(input int d, input int n, input int m, input int ins,
                            input int init_dly, input int calc_dly, input int trace_dly,
                            input int stop_cell);
        int pulses = 0;
        int len;
        int e;
        exp_q.delete();
        for (int i = 1; i <= n; i++)
            for (int j = 1; j <= m; j++)
                exp_q.push_back(i * 256 + j);
        start[d] = 1'b1;
        @(negedge clk);
        start[d] = 1'b0;
        check("init_en",    int'(en_init[d]), 1);
        check("init_we",    int'(we[d]), 1);
        check("init_busy",  int'(busy[d]), 1);
        check("init_cells", cells[d], 0);
        check("init_i",     icur[d], 1);
        check("init_j",     jcur[d], 1);
        repeat (init_dly - 1) @(negedge clk);
        end_init[d] = 1'b1;
        @(negedge clk);
        end_init[d] = 1'b0;
        for (int c = 0; c < n * m; c++) begin
            check("read_en", int'(en_read[d]), 1);
            check("read_we", int'(we[d]), 0);
            repeat (calc_dly - 1) @(negedge clk);
            calculated[d] = 1'b1;
            @(negedge clk);
            calculated[d] = 1'b0;
            e = exp_q.pop_front();
            check("ins_entry",    int'(en_ins[d]), 1);
            check("cell_i",       icur[d], e / 256);
            check("cell_j",       jcur[d], e % 256);
            check("cells_before", cells[d], c);
            if (c == stop_cell) return;
            len = 0;
            while (en_ins[d] && len < ins + 2) begin
                check("ins_we", int'(we[d]), 1);
                len++;
                @(negedge clk);
            end
            check("ins_len",     len, ins);
            check("cells_after", cells[d], c + 1);
            if (c < n * m - 1) begin
                check("next_pulse", int'(change_index[d]), 1);
                check("next_quiet", int'(en_read[d] | en_ins[d] | we[d]), 0);
                if (change_index[d]) pulses++;
                @(negedge clk);
                check("pulse_width", int'(change_index[d]), 0);
            end else begin
                check("trace_en", int'(en_traceB[d]), 1);
            end
        end
        repeat (trace_dly - 1) @(negedge clk);
        end_c[d] = 1'b1;
        @(negedge clk);
        end_c[d] = 1'b0;
        check("done_flag",  int'(done[d]), 1);
        check("done_busy",  int'(busy[d]), 0);
        check("done_trace", int'(en_traceB[d]), 0);
        check("done_cells", cells[d], n * m);
        check("done_i",     icur[d], n);
        check("done_j",     jcur[d], m);
        check("pulses",     pulses, n * m - 1);
        check("queue_left", exp_q.size(), 0);
    endtask

    // Launch a run and get into READ cycle 1 with a one-cycle INIT.
    task automatic enter_read(input int d);
        start[d] = 1'b1;
        @(negedge clk);
        start[d]    = 1'b0;
        end_init[d] = 1'b1;
        @(negedge clk);
        end_init[d] = 1'b0;
        check("enter_read", int'(en_read[d]), 1);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout got=hang exp=finish");
        $fatal(1, "simulation time limit reached");
    end

    initial begin
        rst = '1; start = '0; abort = '0; end_init = '0; calculated = '0; end_c = '0;
        repeat (2) @(negedge clk);
        for (int d = 0; d < 3; d++) check_idle(d, "por");
        rst = '0;
        @(negedge clk);

        // Reset during INS of cell (2,3): outputs drop without a clock edge.
        run_fill(0, 5, 5, 4, 10, 3, 20, 7);
        check("pre_rst_i", icur[0], 2);
        check("pre_rst_j", jcur[0], 3);
        rst[0] = 1'b1;
        #1;
        check_idle(0, "rst_async");
        repeat (2) @(negedge clk);
        check_idle(0, "rst_hold");
        rst[0] = 1'b0;
        @(negedge clk);
        check_idle(0, "rst_release");

        // Full 5x5 fill.
        run_fill(0, 5, 5, 4, 10, 3, 20, -1);

        // 3x7 fill with row wrap.
        run_fill(1, 3, 7, 2, 4, 2, 5, -1);

        // Watchdog: READ without calculated lasts exactly TIMEOUT cycles.
        enter_read(1);
        for (int k = 1; k <= 16; k++) begin
            check("wd_read", int'(en_read[1]), 1);
            check("wd_noerr", int'(error[1]), 0);
            @(negedge clk);
        end
        check("wd_error", int'(error[1]), 1);
        check("wd_en_off", int'({en_init[1], en_read[1], en_ins[1], we[1],
                                 change_index[1], en_traceB[1], busy[1]}), 0);
        start[1] = 1'b1;
        repeat (3) @(negedge clk);
        start[1] = 1'b0;
        check("err_sticky", int'(error[1]), 1);
        check("err_no_init", int'(en_init[1]), 0);
        abort[1] = 1'b1;
        @(negedge clk);
        abort[1] = 1'b0;
        check_idle(1, "err_abort");

        // calculated on the expiry edge wins over the watchdog.
        enter_read(1);
        repeat (15) @(negedge clk);
        calculated[1] = 1'b1;
        @(negedge clk);
        calculated[1] = 1'b0;
        check("race_ins", int'(en_ins[1]), 1);
        check("race_noerr", int'(error[1]), 0);
        abort[1] = 1'b1;
        @(negedge clk);
        abort[1] = 1'b0;
        check_idle(1, "ins_abort");

        // 1x1 run twice (second from DONE), then abort during TRACE.
        run_fill(2, 1, 1, 3, 2, 2, 3, -1);
        run_fill(2, 1, 1, 3, 2, 2, 3, -1);
        enter_read(2);
        calculated[2] = 1'b1;
        @(negedge clk);
        calculated[2] = 1'b0;
        repeat (3) @(negedge clk);
        check("trace_before_abort", int'(en_traceB[2]), 1);
        abort[2] = 1'b1;
        @(negedge clk);
        abort[2] = 1'b0;
        check_idle(2, "trace_abort");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
